blur_window: RTL

- Upstream neighbour of the 5-tap blur stage: turns a raster pixel stream into 5-pixel horizontal windows, one window per input column.
- Replicates the edge pixel at both row borders, so every row of ROW_WIDTH pixels yields exactly ROW_WIDTH windows.
- Paces its output to the blur stage's 3-phase cadence: pulses blur en, holds the window stable, waits for final_stage, then moves on.

---
 rtl/edge_pkg.sv | 21 ++
 rtl/blur_window.sv | 118 +++++++++++
 2 files changed

// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : edge_pkg
// Brief   : Pixel, window and FSM state types shared by the blur pipeline.
// Rev     : 1.0
// ============================================================================
package edge_pkg;

  localparam int PIXEL_BITS  = 8;
  localparam int KERNEL_TAPS = 5;

  typedef logic [KERNEL_TAPS-1:0][PIXEL_BITS-1:0] window_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EMIT   = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/blur_window.sv
`default_nettype none
// ============================================================================
// Module  : blur_window
// Brief   : Raster pixels -> edge-clamped 5-pixel windows, paced to blur cadence.
// Rev     : 1.0
// ============================================================================
module blur_window
  import edge_pkg::*;
#(
  parameter int ROW_WIDTH = 640,
  parameter int COL_BITS  = $clog2(ROW_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [PIXEL_BITS-1:0] in_pixel,
  output logic                  in_ready,
  output window_t               out_pixels,
  output logic                  out_en,
  output logic [COL_BITS-1:0]   out_col,
  input  logic                  blur_final
);

  localparam logic [COL_BITS-1:0] c_COL_ZERO = '0;
  localparam logic [COL_BITS-1:0] c_COL_ONE  = COL_BITS'(1);
  localparam logic [COL_BITS-1:0] c_COL_TWO  = COL_BITS'(2);
  localparam logic [COL_BITS-1:0] c_COL_LAST = COL_BITS'(ROW_WIDTH - 1);

  state_t              r_state;
  logic [COL_BITS-1:0] r_in_col;
  logic [COL_BITS-1:0] r_out_col;
  logic [1:0]          r_flush_cnt;
  window_t             r_win;
  logic                r_out_en;

  logic                w_ready;
  logic                w_accept;
  logic                w_first;
  logic                w_emit;
  logic                w_last;
  logic [COL_BITS-1:0] w_acc_col;

  // Column 0 (explicit or via row wrap) restarts the window with the edge pixel.
  always_comb begin
    w_first   = in_sof || (r_in_col == c_COL_ZERO);
    w_acc_col = w_first ? c_COL_ZERO : r_in_col;
    w_emit    = (w_acc_col >= c_COL_TWO);
    w_last    = (w_acc_col == c_COL_LAST);
    w_ready   = (r_state == ACCEPT) ||
                ((r_state == WAIT) && blur_final && (r_flush_cnt == 2'd0));
    w_accept  = in_valid && w_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCEPT;
      r_in_col    <= c_COL_ZERO;
      r_out_col   <= c_COL_ZERO;
      r_flush_cnt <= 2'd0;
      r_win       <= '0;
      r_out_en    <= 1'b0;
    end else begin
      r_out_en <= 1'b0;
      if (w_accept) begin
        if (w_first) begin
          r_win <= {KERNEL_TAPS{in_pixel}};
        end else begin
          r_win <= {in_pixel, r_win[KERNEL_TAPS-1:1]};
        end
        if (w_last) begin
          r_in_col    <= c_COL_ZERO;
          r_flush_cnt <= 2'd2;
        end else begin
          r_in_col    <= w_acc_col + c_COL_ONE;
          r_flush_cnt <= 2'd0;
        end
        if (w_emit) begin
          r_state   <= EMIT;
          r_out_en  <= 1'b1;
          r_out_col <= w_acc_col - c_COL_TWO;
        end else begin
          r_state <= ACCEPT;
        end
      end else begin
        case (r_state)
          EMIT: begin
            r_state <= WAIT;
          end
          WAIT: begin
            if (blur_final) begin
              // Row tail: replicate the last pixel to centre the final two columns.
              if (r_flush_cnt != 2'd0) begin
                r_win       <= {r_win[KERNEL_TAPS-1], r_win[KERNEL_TAPS-1:1]};
                r_flush_cnt <= r_flush_cnt - 2'd1;
                r_out_col   <= r_out_col + c_COL_ONE;
                r_state     <= EMIT;
                r_out_en    <= 1'b1;
              end else begin
                r_state <= ACCEPT;
              end
            end
          end
          default: begin
            r_state <= ACCEPT;
          end
        endcase
      end
    end
  end

  assign in_ready   = w_ready;
  assign out_pixels = r_win;
  assign out_en     = r_out_en;
  assign out_col    = r_out_col;

endmodule
`default_nettype wire
